// File: rtl/mvm_par_if.sv
// Command/data bus of the matrix-vector multiplier: load/start strobes and
// element input in, result stream and status out.
interface mvm_par_if #(
  parameter int B  = 8,
  parameter int OW = 18
);
  logic                 loadMatrix;
  logic                 loadVector;
  logic                 start;
  logic signed [B-1:0]  data_in;
  logic                 done;
  logic                 out_valid;
  logic signed [OW-1:0] data_out;
  logic                 busy;
  logic                 err;

  modport master (
    output loadMatrix, loadVector, start, data_in,
    input  done, out_valid, data_out, busy, err
  );

  modport slave (
    input  loadMatrix, loadVector, start, data_in,
    output done, out_valid, data_out, busy, err
  );
endinterface

// File: rtl/mvm_par.sv
// K x K signed matrix times K-element vector, P multiply-accumulate lanes
// per cycle, results streamed out one row per cycle.
//
// state   | meaning
// IDLE    | waiting for a single command strobe
// LOAD_M  | capturing K*K matrix elements, row-major
// LOAD_V  | capturing K vector elements
// COMPUTE | K*K/P cycles of P-lane MAC into acc[row]
// DONE    | one-cycle done pulse, first result staged
// OUTPUT  | streaming y[0..K-1] with out_valid
module mvm_par #(
  parameter int K = 4,
  parameter int B = 8,
  parameter int P = 1
) (
  input  logic     clk,
  input  logic     reset,
  mvm_par_if.slave bus
);
  localparam int OW = 2*B + $clog2(K);
  localparam int KK = K*K;
  localparam int CW = $clog2(KK);
  localparam int RW = $clog2(K);

  typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, COMPUTE, DONE, OUTPUT} state_t;
  state_t state, state_nx;

  logic signed [B-1:0]  mat [KK];
  logic signed [B-1:0]  vec [K];
  logic signed [OW-1:0] acc [K];
  logic [CW-1:0]        cnt;
  logic [RW-1:0]        row;
  logic [RW-1:0]        col;
  logic signed [OW-1:0] dout;
  logic                 err_q;
  logic signed [2*B-1:0] prod;
  logic signed [OW-1:0] lane_sum;
  logic                 any_strobe;
  logic                 multi_strobe;
  logic                 last_m, last_v, last_c;

  assign any_strobe   = bus.loadMatrix | bus.loadVector | bus.start;
  assign multi_strobe = (bus.loadMatrix & bus.loadVector) |
                        (bus.loadMatrix & bus.start) |
                        (bus.loadVector & bus.start);

  assign last_m = (cnt == CW'(KK-1));
  assign last_v = (cnt == CW'(K-1));
  assign last_c = (cnt == CW'(KK-P));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (any_strobe && !multi_strobe) begin
          if (bus.loadMatrix)      state_nx = LOAD_M;
          else if (bus.loadVector) state_nx = LOAD_V;
          else                     state_nx = COMPUTE;
        end
      end
      LOAD_M:  if (last_m) state_nx = IDLE;
      LOAD_V:  if (last_v) state_nx = IDLE;
      COMPUTE: if (last_c) state_nx = DONE;
      DONE:    state_nx = OUTPUT;
      OUTPUT:  if (last_v) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // cnt doubles as the row-major matrix index during COMPUTE, stepping by P
  always_comb begin
    lane_sum = '0;
    prod     = '0;
    for (int l = 0; l < P; l++) begin
      prod     = mat[cnt + CW'(l)] * vec[col + RW'(l)];
      lane_sum = lane_sum + {{(OW-2*B){prod[2*B-1]}}, prod};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      row   <= '0;
      col   <= '0;
      dout  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < KK; i++) mat[i] <= '0;
      for (int i = 0; i < K; i++) begin
        vec[i] <= '0;
        acc[i] <= '0;
      end
    end else begin
      state <= state_nx;
      err_q <= any_strobe && ((state != IDLE) || multi_strobe);
      case (state)
        IDLE: begin
          cnt <= '0;
          row <= '0;
          col <= '0;
          if (state_nx == COMPUTE)
            for (int i = 0; i < K; i++) acc[i] <= '0;
        end
        LOAD_M: begin
          mat[cnt] <= bus.data_in;
          cnt      <= cnt + 1'b1;
        end
        LOAD_V: begin
          vec[cnt[RW-1:0]] <= bus.data_in;
          cnt              <= cnt + 1'b1;
        end
        COMPUTE: begin
          acc[row] <= acc[row] + lane_sum;
          cnt      <= cnt + CW'(P);
          if (col == RW'(K-P)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + RW'(P);
          end
        end
        DONE: begin
          dout <= acc[0];
          cnt  <= '0;
        end
        OUTPUT: begin
          if (!last_v) dout <= acc[cnt[RW-1:0] + 1'b1];
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.out_valid = (state == OUTPUT);
  assign bus.data_out  = dout;
  assign bus.err       = err_q;
endmodule
